// File: rtl/stopwatch_pkg.sv
// Shared types and default parameters for the BCD stopwatch count source.
package stopwatch_pkg;

    typedef enum logic {STOP = 1'b0, RUN = 1'b1} sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam int DEF_TICK_DIV        = 1_000_000;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_SCAN_BITS       = 20;

    localparam bcd_t BCD_NINE = 4'd9;

endpackage

// File: rtl/button_debounce.sv
// Raw pushbutton to single-cycle press pulse: 2-flop synchroniser, stable-high
// counter and a one-shot that re-arms only after the input goes low.
module button_debounce import stopwatch_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(DEBOUNCE_CYCLES);

    logic          sync1_r;
    logic          sync2_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          press_r;
    logic          press_next_s;

    // The counter saturates at DEBOUNCE_CYCLES, which is what suppresses repeat pulses.
    always_comb begin
        cnt_next_s   = cnt_r;
        press_next_s = 1'b0;
        if (!sync2_r) begin
            cnt_next_s = '0;
        end else if (cnt_r != CNT_SAT) begin
            cnt_next_s   = cnt_r + CW'(1);
            press_next_s = (cnt_r == CNT_LAST);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Synchroniser, debounce counter and registered press pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            cnt_r   <= '0;
            press_r <= 1'b0;
        end else begin
            sync1_r <= btn_in;
            sync2_r <= sync1_r;
            cnt_r   <= cnt_next_s;
            press_r <= press_next_s;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/stopwatch_counter.sv
// Start/stop/clear stopwatch keeping SS.hh in BCD, plus the free-running
// display scan counter that selects the active digit.
module stopwatch_counter import stopwatch_pkg::*; #(
    parameter int TICK_DIV        = DEF_TICK_DIV,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SCAN_BITS       = DEF_SCAN_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_clear,
    output logic [15:0] count,
    output logic [2:0]  mpx,
    output logic        running,
    output logic        ovf
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    sw_state_t            state_r;
    sw_state_t            state_next_s;
    logic [PW-1:0]        presc_r;
    logic [PW-1:0]        presc_next_s;
    bcd_t [3:0]           digit_r;
    bcd_t [3:0]           digit_inc_s;
    bcd_t [3:0]           digit_next_s;
    logic                 carry_s;
    logic                 tick_s;
    logic                 ovf_r;
    logic                 ovf_next_s;
    logic [SCAN_BITS-1:0] scan_r;
    logic                 start_press_s;
    logic                 clear_press_s;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_btn (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_start),
        .press  (start_press_s)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_btn (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_clear),
        .press  (clear_press_s)
    );

    // Clear outranks start so a simultaneous press always lands in STOP.
    always_comb begin
        state_next_s = state_r;
        if (clear_press_s) begin
            state_next_s = STOP;
        end else if (start_press_s) begin
            case (state_r)
                STOP:    state_next_s = RUN;
                RUN:     state_next_s = STOP;
                default: state_next_s = STOP;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    assign tick_s = (state_r == RUN) && (presc_r == PRESC_LAST);

    // Ripple BCD increment; carry_s left high after digit 3 means 99.99 wrapped.
    always_comb begin
        carry_s     = tick_s;
        digit_inc_s = digit_r;
        for (int i = 0; i < 4; i++) begin
            if (carry_s) begin
                if (digit_r[i] == BCD_NINE) begin
                    digit_inc_s[i] = 4'd0;
                end else begin
                    digit_inc_s[i] = digit_r[i] + 4'd1;
                    carry_s        = 1'b0;
                end
            end else begin
                digit_inc_s[i] = digit_r[i];
            end
        end
    end

    // Prescaler and digits hold in STOP so a pause keeps the partial hundredth.
    always_comb begin
        presc_next_s = presc_r;
        digit_next_s = digit_r;
        ovf_next_s   = 1'b0;
        if (clear_press_s) begin
            presc_next_s = '0;
            digit_next_s = '0;
        end else if (state_r == RUN) begin
            presc_next_s = tick_s ? '0 : presc_r + PW'(1);
            digit_next_s = digit_inc_s;
            ovf_next_s   = carry_s;
        end else begin
            presc_next_s = presc_r;
        end
    end

    // State, time value, overflow pulse and scan counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= STOP;
            presc_r <= '0;
            digit_r <= '0;
            ovf_r   <= 1'b0;
            scan_r  <= '0;
        end else begin
            state_r <= state_next_s;
            presc_r <= presc_next_s;
            digit_r <= digit_next_s;
            ovf_r   <= ovf_next_s;
            scan_r  <= scan_r + SCAN_BITS'(1);
        end
    end

    assign count   = digit_r;
    assign mpx     = scan_r[SCAN_BITS-1 -: 3];
    assign running = (state_r == RUN);
    assign ovf     = ovf_r;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench: a cycle-level reference model pushes the expected outputs
// each edge; a monitor on the falling edge pops and compares.
module tb_stopwatch_counter;

    localparam int TD = 4;
    localparam int DC = 3;
    localparam int SB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_start;
    logic        btn_clear;
    logic [15:0] count;
    logic [2:0]  mpx;
    logic        running;
    logic        ovf;

    always #5 clk = ~clk;

    stopwatch_counter #(
        .TICK_DIV        (TD),
        .DEBOUNCE_CYCLES (DC),
        .SCAN_BITS       (SB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .count     (count),
        .mpx       (mpx),
        .running   (running),
        .ovf       (ovf)
    );

    typedef struct packed {
        logic [15:0] count;
        logic [2:0]  mpx;
        logic        running;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: time kept as integer hundredths, buttons as run lengths
    // of raw high samples with a fixed 3-cycle latency to the press pulse.
    int m_hs    = 0;
    int m_presc = 0;
    int m_scan  = 0;
    int m_len_s = 0;
    int m_len_c = 0;
    bit m_running = 1'b0;
    bit m_ovf     = 1'b0;
    bit pipe_s[3] = '{1'b0, 1'b0, 1'b0};
    bit pipe_c[3] = '{1'b0, 1'b0, 1'b0};

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    always @(posedge clk) begin : model
        bit ps;
        bit pc;
        bit tick;
        ps = pipe_s[0];
        pc = pipe_c[0];
        if (rst) begin
            m_hs = 0; m_presc = 0; m_scan = 0; m_len_s = 0; m_len_c = 0;
            m_running = 1'b0; m_ovf = 1'b0;
            for (int i = 0; i < 3; i++) begin
                pipe_s[i] = 1'b0;
                pipe_c[i] = 1'b0;
            end
        end else begin
            m_len_s = btn_start ? m_len_s + 1 : 0;
            m_len_c = btn_clear ? m_len_c + 1 : 0;
            pipe_s[0] = pipe_s[1]; pipe_s[1] = pipe_s[2]; pipe_s[2] = (m_len_s == DC);
            pipe_c[0] = pipe_c[1]; pipe_c[1] = pipe_c[2]; pipe_c[2] = (m_len_c == DC);
            tick = m_running && (m_presc == TD - 1);
            m_ovf = 1'b0;
            if (pc) begin
                m_running = 1'b0; m_presc = 0; m_hs = 0;
            end else begin
                if (m_running) begin
                    m_presc = (m_presc + 1) % TD;
                    if (tick) begin
                        if (m_hs == 9999) begin
                            m_hs = 0; m_ovf = 1'b1;
                        end else begin
                            m_hs = m_hs + 1;
                        end
                    end
                end
                if (ps) m_running = !m_running;
            end
            m_scan = (m_scan + 1) % (1 << SB);
        end
        exp_q.push_back('{to_bcd(m_hs), 3'(m_scan >> 1), m_running, m_ovf});
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{count, mpx, running, ovf};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got count=%h mpx=%0d running=%b ovf=%b want count=%h mpx=%0d running=%b ovf=%b",
                         $time, a.count, a.mpx, a.running, a.ovf, e.count, e.mpx, e.running, e.ovf);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn(input logic s, input logic c, input int hold);
        btn_start = s;
        btn_clear = c;
        repeat (hold) @(negedge clk);
        btn_start = 1'b0;
        btn_clear = 1'b0;
    endtask

    // Waits for a model condition (hs < 0 means any count) within a cycle budget.
    task automatic wait_model(input int hs, input int presc, input int limit, input string name);
        int n = 0;
        while (!((hs < 0 || m_hs == hs) && m_presc == presc && m_running) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL wait_%s budget %0d expired, got hs=%0d presc=%0d want hs=%0d presc=%0d",
                     name, limit, m_hs, m_presc, hs, presc);
        end
    endtask

    initial begin
        rst       = 1'b1;
        btn_start = 1'b0;
        btn_clear = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(40);

        for (int i = 0; i < 12; i++) begin
            btn_start = (i % 2 == 0);
            @(negedge clk);
        end
        btn_start = 1'b0;
        cycles(10);

        press_btn(1'b1, 1'b0, 10);
        cycles(44);

        wait_model(-1, 0, 8, "pause");
        press_btn(1'b1, 1'b0, 5);
        cycles(50);
        press_btn(1'b1, 1'b0, 5);
        cycles(30);

        wait_model(9999, 0, 45000, "wrap");
        cycles(12);

        wait_model(41, 0, 400, "clear");
        press_btn(1'b1, 1'b1, 5);
        cycles(20);

        btn_start = 1'b1;
        cycles(2);
        rst = 1'b1;
        cycles(1);
        rst       = 1'b0;
        btn_start = 1'b0;
        cycles(20);

        repeat (300) begin
            int act;
            int hold;
            act  = int'($urandom_range(0, 9));
            hold = int'($urandom_range(1, 7));
            if (act < 5) begin
                press_btn(1'b1, 1'b0, hold);
            end else if (act < 7) begin
                press_btn(1'b0, 1'b1, hold);
            end else if (act == 7) begin
                press_btn(1'b1, 1'b1, hold);
            end else if (act == 8) begin
                rst = 1'b1;
                cycles(1);
                rst = 1'b0;
            end else begin
                cycles(hold);
            end
            cycles(int'($urandom_range(0, 12)));
        end

        cycles(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
